gun_fire_controller: RTL and testbench
======================================

// Module: gun_fire_controller
// PURPOSE
// - Sits downstream of the gun heat counter: consumes shoot request plus 4-bit heat level, decides when a shot is emitted.
// - Issues one bullet-spawn request per fire interval to the projectile manager via valid/ready, carrying the ship x position latched at fire time.
// - Enforces overheat lockout with hysteresis; exports status for HUD/LEDs.
// PARAMETERS
// - FIRE_INTERVAL  25'd12_499_999  clock cycles between shots (4 Hz at 50 MHz); value N gives N+1 cycles
// - HEAT_LOCK      4'd15           heat >= this enters OVERHEAT
// - HEAT_UNLOCK    4'd8            heat <= this leaves OVERHEAT (HEAT_UNLOCK < HEAT_LOCK required)
// - X_W            8               width of ship x coordinate
// PORTS
// - clock          in   1    50 MHz system clock
// - reset          in   1    synchronous, active-high; also driven by game start
// - shoot          in   1    player fire request (level, from SW[0])
// - heat           in   4    current gun heat level, 0..15
// - ship_x         in   X_W  current ship x position
// - spawn_ready    in   1    projectile manager can accept a bullet
// - spawn_valid    out  1    bullet spawn request pending
// - spawn_x        out  X_W  x position of requested bullet; stable while spawn_valid
// - overheated     out  1    high in OVERHEAT state
// - shots_fired    out  8    count of accepted spawns, wraps 255->0
// BEHAVIOUR
// - Reset (synchronous, takes priority over everything): state=IDLE, spawn_valid=0, spawn_x=0, overheated=0, shots_fired=0, interval timer cleared to 0.
// - States: IDLE, REQ, RELOAD, OVERHEAT.
// - IDLE: if heat >= HEAT_LOCK -> OVERHEAT (checked first); else if shoot -> REQ, latch spawn_x<=ship_x, spawn_valid<=1 next cycle.
// - REQ: spawn_valid held 1, spawn_x held stable regardless of ship_x/shoot/heat changes.
//   Transfer occurs on cycle with spawn_valid & spawn_ready: shots_fired++, spawn_valid<=0, timer<=FIRE_INTERVAL, -> RELOAD.
//   Request is never withdrawn once raised, even if shoot drops or heat reaches HEAT_LOCK.
// - RELOAD: timer decrements each cycle; at timer==0 -> OVERHEAT if heat >= HEAT_LOCK, else REQ (latch ship_x) if shoot, else IDLE.
//   Holding shoot continuously yields exactly one spawn per FIRE_INTERVAL+1 cycles when spawn_ready is always 1.
// - OVERHEAT: overheated=1, no requests; leave to IDLE when heat <= HEAT_UNLOCK (overheated=0 same cycle as state change). Heat values between UNLOCK and LOCK keep lockout.
// - Latency: shoot rising in IDLE -> spawn_valid high 1 cycle later; accept -> spawn_valid low next cycle.
// - Back-to-back: no zero-gap second spawn; minimum gap between accepted spawns is FIRE_INTERVAL+1 cycles.
// - Reset mid-REQ drops spawn_valid next edge with no transfer counted; reset mid-RELOAD clears timer.
// - shots_fired is modulo 256; no saturation.
// - heat is sampled, not modified; heat counter upstream owns increment/decrement.
// STRUCTURE
// - Shared header starflux_defs.vh: state encodings (2-bit localparams), default FIRE_INTERVAL, HEAT_LOCK/HEAT_UNLOCK, X_W.
// - One sub-module: fire_interval_timer (load value, decrement-to-zero, done flag, sync clear); FSM, latch and counter stay in top.
// - All registers in single clock domain; no combinational path from spawn_ready to spawn_valid.
// TESTING (bench uses FIRE_INTERVAL=4)
// - Reset then shoot=1, heat=0, ship_x=40, ready=1 -> spawn_valid 1 cycle after shoot; spawn_x=40; shots_fired=1; next spawn exactly 5 cycles later.
// - ready=0 for 10 cycles during REQ while ship_x changes 40->90 -> spawn_valid held, spawn_x stays 40; count increments once when ready rises.
// - heat=15 in IDLE with shoot=1 -> overheated=1, no spawn; heat steps 14..9 -> still locked; heat=8 -> overheated=0, then spawn resumes.
// - shoot released in RELOAD -> return to IDLE after timer expiry, no further spawn_valid.
// - 256 accepted spawns -> shots_fired wraps to 0.
// - reset asserted while spawn_valid=1 -> spawn_valid=0, shots_fired=0, state IDLE on next edge.

Source files
------------

// File: rtl/gun_fire_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gun_fire_controller_pkg
// Description : Shared state encoding and default tuning for the gun fire
//               controller and its reload timer.
// Revision    : 1.0 - initial release
// ============================================================================
package gun_fire_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_RELOAD   = 2'd2,
        ST_OVERHEAT = 2'd3
    } gfc_state_t;

    localparam int unsigned        TIMER_W               = 25;
    localparam logic [TIMER_W-1:0] DEFAULT_FIRE_INTERVAL = 25'd12_499_999;
    localparam logic [3:0]         DEFAULT_HEAT_LOCK     = 4'd15;
    localparam logic [3:0]         DEFAULT_HEAT_UNLOCK   = 4'd8;
    localparam int unsigned        DEFAULT_X_W           = 8;

endpackage
`default_nettype wire

// File: rtl/fire_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : fire_interval_timer
// Description : Loadable down-counter that flags the final reload cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fire_interval_timer
    import gun_fire_controller_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // Done on the last count so the next request is raised without an
    // extra idle cycle: a load of N spaces accepted spawns N+1 cycles apart.
    assign o_done = (r_count <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/gun_fire_controller.sv
`default_nettype none
// ============================================================================
// Module      : gun_fire_controller
// Description : Rate-limited bullet spawn requester with overheat lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module gun_fire_controller
    import gun_fire_controller_pkg::*;
#(
    parameter logic [TIMER_W-1:0] FIRE_INTERVAL = DEFAULT_FIRE_INTERVAL,
    parameter logic [3:0]         HEAT_LOCK     = DEFAULT_HEAT_LOCK,
    parameter logic [3:0]         HEAT_UNLOCK   = DEFAULT_HEAT_UNLOCK,
    parameter int unsigned        X_W           = DEFAULT_X_W
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           shoot,
    input  logic [3:0]     heat,
    input  logic [X_W-1:0] ship_x,
    input  logic           spawn_ready,
    output logic           spawn_valid,
    output logic [X_W-1:0] spawn_x,
    output logic           overheated,
    output logic [7:0]     shots_fired
);

    gfc_state_t     r_state;
    gfc_state_t     w_state_next;
    logic [X_W-1:0] r_spawn_x;
    logic [7:0]     r_shots_fired;
    logic           w_latch_x;
    logic           w_accept;
    logic           w_timer_done;
    logic           w_hot;
    logic           w_cool;

    assign w_hot  = (heat >= HEAT_LOCK);
    assign w_cool = (heat <= HEAT_UNLOCK);

    fire_interval_timer #(
        .WIDTH        (TIMER_W)
    ) u_timer (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_accept),
        .i_load_value (FIRE_INTERVAL),
        .o_done       (w_timer_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_spawn_x     <= '0;
            r_shots_fired <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (w_latch_x) begin
                r_spawn_x <= ship_x;
            end
            if (w_accept) begin
                r_shots_fired <= r_shots_fired + 8'd1;
            end
        end
    end

    // A raised request is never withdrawn: REQ only exits on a transfer.
    always_comb begin
        w_state_next = r_state;
        w_latch_x    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hot) begin
                    w_state_next = ST_OVERHEAT;
                end else if (shoot) begin
                    w_state_next = ST_REQ;
                    w_latch_x    = 1'b1;
                end
            end
            ST_REQ: begin
                if (spawn_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RELOAD;
                end
            end
            ST_RELOAD: begin
                if (w_timer_done) begin
                    if (w_hot) begin
                        w_state_next = ST_OVERHEAT;
                    end else if (shoot) begin
                        w_state_next = ST_REQ;
                        w_latch_x    = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_OVERHEAT: begin
                if (w_cool) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign spawn_valid = (r_state == ST_REQ);
    assign overheated  = (r_state == ST_OVERHEAT);
    assign spawn_x     = r_spawn_x;
    assign shots_fired = r_shots_fired;

endmodule
`default_nettype wire

// File: tb/tb_gun_fire_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_gun_fire_controller
// Description : Self-checking bench for gun_fire_controller (FIRE_INTERVAL=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gun_fire_controller;

    logic       clock;
    logic       reset;
    logic       shoot;
    logic [3:0] heat;
    logic [7:0] ship_x;
    logic       spawn_ready;
    logic       spawn_valid;
    logic [7:0] spawn_x;
    logic       overheated;
    logic [7:0] shots_fired;

    int         errors;
    int         checks;
    int         cyc;
    logic [7:0] exp_shots;
    logic [7:0] sb[$];

    gun_fire_controller #(
        .FIRE_INTERVAL (25'd4),
        .HEAT_LOCK     (4'd15),
        .HEAT_UNLOCK   (4'd8),
        .X_W           (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .shoot       (shoot),
        .heat        (heat),
        .ship_x      (ship_x),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_x     (spawn_x),
        .overheated  (overheated),
        .shots_fired (shots_fired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits (bounded) for a valid/ready handshake; returns one cycle after it.
    task automatic wait_accept(output bit found, output int acc_cyc, output logic [7:0] x_seen);
        found   = 1'b0;
        acc_cyc = 0;
        x_seen  = 8'd0;
        for (int i = 0; i < 64; i++) begin
            if (spawn_valid && spawn_ready) begin
                found   = 1'b1;
                acc_cyc = cyc;
                x_seen  = spawn_x;
                tick();
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (spawn_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b, required 0", spawn_valid);
        end
        checks++;
        if (spawn_x !== 8'd0) begin
            errors++; $display("FAIL reset_spawn_x: got %0d, required 0", spawn_x);
        end
        checks++;
        if (overheated !== 1'b0) begin
            errors++; $display("FAIL reset_overheated: got %b, required 0", overheated);
        end
        checks++;
        if (shots_fired !== 8'd0) begin
            errors++; $display("FAIL reset_shots: got %0d, required 0", shots_fired);
        end
        reset     = 1'b0;
        exp_shots = 8'd0;
        sb.delete();
        tick();
    endtask

    task automatic test_basic_fire();
        bit         found;
        int         c1;
        int         c2;
        logic [7:0] xs;
        logic [7:0] ex;
        heat = 4'd0; ship_x = 8'd40; spawn_ready = 1'b1; shoot = 1'b1;
        sb.push_back(8'd40);
        tick();
        checks++;
        if (spawn_valid !== 1'b1) begin
            errors++; $display("FAIL basic_latency: valid=%b one cycle after shoot, required 1", spawn_valid);
        end
        for (int k = 0; k < 2; k++) begin
            wait_accept(found, c2, xs);
            checks++;
            if (!found || sb.size() == 0) begin
                errors++; $display("FAIL basic_accept%0d: no transfer seen, required one", k);
            end else begin
                ex = sb.pop_front();
                if (xs !== ex) begin
                    errors++; $display("FAIL basic_spawn_x%0d: got %0d, required %0d", k, xs, ex);
                end
                exp_shots = exp_shots + 8'd1;
                checks++;
                if (shots_fired !== exp_shots) begin
                    errors++; $display("FAIL basic_shots%0d: got %0d, required %0d", k, shots_fired, exp_shots);
                end
                checks++;
                if (spawn_valid !== 1'b0) begin
                    errors++; $display("FAIL basic_drop%0d: valid=%b after accept, required 0", k, spawn_valid);
                end
            end
            if (k == 0) begin
                c1 = c2;
                sb.push_back(8'd40);
            end
        end
        checks++;
        if (c2 - c1 != 5) begin
            errors++; $display("FAIL basic_gap: got %0d cycles, required 5", c2 - c1);
        end
    endtask

    task automatic test_release();
        int seen;
        seen  = 0;
        shoot = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (spawn_valid) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL release_no_spawn: valid seen %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_backpressure();
        bit         found;
        int         c;
        logic [7:0] xs;
        logic [7:0] ex;
        spawn_ready = 1'b0; ship_x = 8'd40; shoot = 1'b1; heat = 4'd0;
        sb.push_back(8'd40);
        tick();
        for (int i = 1; i <= 10; i++) begin
            ship_x = 8'(40 + 5 * i);
            shoot  = i[0];
            heat   = (i >= 5) ? 4'd15 : 4'd0;
            tick();
            checks++;
            if ({spawn_valid, spawn_x} !== {1'b1, 8'd40}) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b x=%0d, required valid=1 x=40", i, spawn_valid, spawn_x);
            end
        end
        shoot = 1'b0; spawn_ready = 1'b1;
        wait_accept(found, c, xs);
        checks++;
        if (!found || sb.size() == 0) begin
            errors++; $display("FAIL bp_accept: no transfer seen, required one");
        end else begin
            ex = sb.pop_front();
            if (xs !== ex) begin
                errors++; $display("FAIL bp_spawn_x: got %0d, required %0d", xs, ex);
            end
            exp_shots = exp_shots + 8'd1;
            checks++;
            if (shots_fired !== exp_shots) begin
                errors++; $display("FAIL bp_shots: got %0d, required %0d", shots_fired, exp_shots);
            end
        end
        repeat (8) tick();
        checks++;
        if (overheated !== 1'b1) begin
            errors++; $display("FAIL bp_reload_to_overheat: got %b, required 1", overheated);
        end
        heat = 4'd0;
        repeat (2) tick();
        checks++;
        if (overheated !== 1'b0) begin
            errors++; $display("FAIL bp_cooldown: got %b, required 0", overheated);
        end
    endtask

    task automatic test_overheat();
        bit         found;
        int         c;
        logic [7:0] xs;
        logic [7:0] ex;
        spawn_ready = 1'b1; shoot = 1'b1; heat = 4'd15; ship_x = 8'd77;
        tick();
        checks++;
        if ({overheated, spawn_valid} !== 2'b10) begin
            errors++; $display("FAIL oh_enter: overheated=%b valid=%b, required 1 0", overheated, spawn_valid);
        end
        for (int h = 14; h >= 9; h--) begin
            heat = 4'(h);
            tick();
            checks++;
            if ({overheated, spawn_valid} !== 2'b10) begin
                errors++;
                $display("FAIL oh_hold_heat%0d: overheated=%b valid=%b, required 1 0", h, overheated, spawn_valid);
            end
        end
        heat = 4'd8;
        sb.push_back(8'd77);
        tick();
        checks++;
        if ({overheated, spawn_valid} !== 2'b00) begin
            errors++; $display("FAIL oh_exit: overheated=%b valid=%b, required 0 0", overheated, spawn_valid);
        end
        wait_accept(found, c, xs);
        checks++;
        if (!found || sb.size() == 0) begin
            errors++; $display("FAIL oh_resume: no transfer seen, required one");
        end else begin
            ex = sb.pop_front();
            if (xs !== ex) begin
                errors++; $display("FAIL oh_spawn_x: got %0d, required %0d", xs, ex);
            end
            exp_shots = exp_shots + 8'd1;
            checks++;
            if (shots_fired !== exp_shots) begin
                errors++; $display("FAIL oh_shots: got %0d, required %0d", shots_fired, exp_shots);
            end
        end
        shoot = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset_mid_req();
        spawn_ready = 1'b0; shoot = 1'b1; ship_x = 8'd12; heat = 4'd0;
        tick();
        checks++;
        if (spawn_valid !== 1'b1) begin
            errors++; $display("FAIL rst_req_setup: valid=%b, required 1", spawn_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; shoot = 1'b0; spawn_ready = 1'b1;
        exp_shots = 8'd0;
        checks++;
        if ({spawn_valid, overheated, shots_fired, spawn_x} !== {1'b0, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL rst_mid_req: valid=%b oh=%b shots=%0d x=%0d, required 0 0 0 0",
                     spawn_valid, overheated, shots_fired, spawn_x);
        end
        repeat (3) tick();
        checks++;
        if (spawn_valid !== 1'b0) begin
            errors++; $display("FAIL rst_idle: valid=%b, required 0", spawn_valid);
        end
    endtask

    task automatic test_wrap();
        bit         found;
        int         c;
        logic [7:0] xs;
        logic [7:0] ex;
        spawn_ready = 1'b1; heat = 4'd0;
        for (int n = 0; n < 256; n++) begin
            ship_x = 8'(n * 7 + 3);
            sb.push_back(ship_x);
            shoot = 1'b1;
            wait_accept(found, c, xs);
            checks++;
            if (!found || sb.size() == 0) begin
                errors++; $display("FAIL wrap_accept%0d: no transfer seen, required one", n);
                break;
            end
            ex = sb.pop_front();
            if (xs !== ex) begin
                errors++; $display("FAIL wrap_spawn_x%0d: got %0d, required %0d", n, xs, ex);
            end
            exp_shots = exp_shots + 8'd1;
            checks++;
            if (shots_fired !== exp_shots) begin
                errors++; $display("FAIL wrap_shots%0d: got %0d, required %0d", n, shots_fired, exp_shots);
            end
        end
        shoot = 1'b0;
        checks++;
        if (shots_fired !== 8'd0) begin
            errors++; $display("FAIL wrap_to_zero: got %0d, required 0", shots_fired);
        end
    endtask

    initial begin
        errors = 0; checks = 0; exp_shots = 8'd0;
        reset = 1'b1; shoot = 1'b0; heat = 4'd0; ship_x = 8'd0; spawn_ready = 1'b0;
        tick();
        test_reset();
        test_basic_fire();
        test_release();
        test_backpressure();
        test_overheat();
        test_reset_mid_req();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
